// File: rtl/uart_tx_fifo_engine_if.sv
// Host-side bundle for uart_tx_fifo_engine: frame config, write port, FIFO
// status and the serial line.
interface uart_tx_fifo_engine_if #(
  parameter int FIFO_DEPTH = 16,
  parameter int K_W        = 19
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [K_W-1:0] k;
  logic           eight;
  logic           pen;
  logic           ohel;
  logic           two_stop;
  logic           wr;
  logic [7:0]     wdata;
  logic           clr_ovf;
  logic           TxRdy;
  logic           empty;
  logic [CW-1:0]  count;
  logic           busy;
  logic           ovf;
  logic           Tx;

  modport master (
    output k, eight, pen, ohel, two_stop, wr, wdata, clr_ovf,
    input  TxRdy, empty, count, busy, ovf, Tx
  );

  modport slave (
    input  k, eight, pen, ohel, two_stop, wr, wdata, clr_ovf,
    output TxRdy, empty, count, busy, ovf, Tx
  );
endinterface

// File: rtl/uart_tx_fifo_engine.sv
// FIFO-buffered UART transmitter, 7/8 data bits, opt. parity, 1/2 stop bits.
// Define UART_TX_BREAK_EN to add the brk input and the line-break states.
module uart_tx_fifo_engine #(
  parameter int FIFO_DEPTH = 16,
  parameter int K_W        = 19
) (
  input  logic clk,
  input  logic rst,
`ifdef UART_TX_BREAK_EN
  input  logic brk,
`endif
  uart_tx_fifo_engine_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef UART_TX_BREAK_EN
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, BREAK, BRKEND} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;
`endif

  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]  wptr_q, rptr_q;
  logic [CW-1:0]  count_q, count_d;
  logic           full, push, pop, ovf_q, tx_q;
  state_t         state_q;
  logic [K_W-1:0] bt_q;
  logic [3:0]     bitcnt_q, nlast_q, nlast_d;
  logic [10:0]    shreg_q;
  logic [11:0]    frame_d;
  logic [7:0]     data_d;
  logic           par_d, btu;

  assign full = (count_q == CW'(FIFO_DEPTH));
  assign push = bus.wr && !full;
  assign pop  = (state_q == LOAD);
  assign btu  = (bt_q == bus.k);

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      count_q <= count_d;
      if (bus.wr && full) ovf_q <= 1'b1;
      else if (bus.clr_ovf) ovf_q <= 1'b0;
    end
  end

  // Frame image {1..., parity?, data, start}; unused upper bits stay 1 as stop bits.
  always_comb begin
    data_d  = bus.eight ? mem_q[rptr_q] : {1'b0, mem_q[rptr_q][6:0]};
    par_d   = (^data_d) ^ bus.ohel;
    frame_d = '1;
    frame_d[0] = 1'b0;
    if (bus.eight) begin
      frame_d[8:1] = data_d;
      if (bus.pen) frame_d[9] = par_d;
    end else begin
      frame_d[7:1] = data_d[6:0];
      if (bus.pen) frame_d[8] = par_d;
    end
    nlast_d = 4'd8 + {3'b0, bus.eight} + {3'b0, bus.pen}
            + {3'b0, bus.two_stop};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      tx_q     <= 1'b1;
      bt_q     <= '0;
      bitcnt_q <= '0;
      nlast_q  <= '0;
      shreg_q  <= '1;
    end else begin
      unique case (state_q)
        IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (brk) begin
            state_q <= BREAK;
            tx_q    <= 1'b0;
          end else
`endif
          if (count_q != '0) state_q <= LOAD;
        end
        LOAD: begin
          shreg_q  <= frame_d[11:1];
          nlast_q  <= nlast_d;
          tx_q     <= frame_d[0];
          bt_q     <= '0;
          bitcnt_q <= '0;
          state_q  <= SHIFT;
        end
        SHIFT: begin
          if (btu) begin
            bt_q     <= '0;
            shreg_q  <= {1'b1, shreg_q[10:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
            tx_q     <= shreg_q[0];
            if (bitcnt_q == nlast_q) begin
              tx_q <= 1'b1;
`ifdef UART_TX_BREAK_EN
              if (brk) begin
                state_q <= BREAK;
                tx_q    <= 1'b0;
              end else
`endif
              if (count_q != '0) state_q <= LOAD;
              else               state_q <= IDLE;
            end
          end else begin
            bt_q <= bt_q + 1'b1;
          end
        end
`ifdef UART_TX_BREAK_EN
        BREAK: begin
          if (!brk) begin
            state_q <= BRKEND;
            tx_q    <= 1'b1;
            bt_q    <= '0;
          end
        end
        BRKEND: begin
          if (btu) begin
            bt_q    <= '0;
            state_q <= IDLE;
          end else begin
            bt_q <= bt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.TxRdy = !full;
  assign bus.empty = (count_q == '0);
  assign bus.count = count_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.ovf   = ovf_q;
  assign bus.Tx    = tx_q;
endmodule

// File: tb/tb_uart_tx_fifo_engine.sv
// Bench for uart_tx_fifo_engine: per-clock Tx waveform compared against a
// frame-level reference built from the byte/config rules.
module tb_uart_tx_fifo_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
`ifdef UART_TX_BREAK_EN
  logic brk = 1'b0;
`endif

  uart_tx_fifo_engine_if #(.FIFO_DEPTH(16), .K_W(19)) bus ();

  uart_tx_fifo_engine #(.FIFO_DEPTH(16), .K_W(19)) dut (
    .clk (clk),
    .rst (rst),
`ifdef UART_TX_BREAK_EN
    .brk (brk),
`endif
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int busy_cnt = 0;
  bit exp_tx[$];
  logic [7:0] wq[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int kk, input bit e8, input bit p,
                     input bit odd, input bit two);
    bus.k        = 19'(kk);
    bus.eight    = e8;
    bus.pen      = p;
    bus.ohel     = odd;
    bus.two_stop = two;
  endtask

  // Reference frame: start, data LSB-first, parity, stops; each bit kk+1 clocks.
  function automatic void add_frame(input logic [7:0] b, input bit e8,
                                    input bit p, input bit odd,
                                    input bit two, input int kk);
    bit q[$];
    int nd;
    int ones;
    nd = e8 ? 8 : 7;
    q.push_back(1'b0);
    for (int i = 0; i < nd; i++) q.push_back(b[i]);
    if (p) begin
      ones = 0;
      for (int i = 0; i < nd; i++) ones += int'(b[i]);
      q.push_back(((ones % 2) == 1) ^ odd);
    end
    q.push_back(1'b1);
    if (two) q.push_back(1'b1);
    foreach (q[i]) repeat (kk + 1) exp_tx.push_back(q[i]);
  endfunction

  function automatic void add_idle(input int n);
    repeat (n) exp_tx.push_back(1'b1);
  endfunction

  task automatic step();
    bit e;
    if (wq.size() != 0) begin
      bus.wr    = 1'b1;
      bus.wdata = wq.pop_front();
    end else begin
      bus.wr = 1'b0;
    end
    @(posedge clk);
    #1;
    bus.wr = 1'b0;
    if (bus.busy) busy_cnt++;
    if (exp_tx.size() != 0) e = exp_tx.pop_front();
    else e = 1'b1;
    chk("tx", 32'(bus.Tx), 32'(e));
  endtask

  task automatic run_all();
    while (exp_tx.size() != 0 || wq.size() != 0) step();
    step();
  endtask

  initial begin
    logic [7:0] b;
    int kk, n;
    bit e8, p, odd, two;

    cfg(4, 1, 1, 0, 0);
    bus.wr = 1'b0;
    bus.wdata = 8'h00;
    bus.clr_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_tx", 32'(bus.Tx), 1);
    chk("rst_txrdy", 32'(bus.TxRdy), 1);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    rst = 1'b0;
    step();

    // 8E1 0x55, busy for 55 bit clocks plus the load cycle
    cfg(4, 1, 1, 0, 0);
    wq.push_back(8'h55);
    add_idle(2);
    add_frame(8'h55, 1, 1, 0, 0, 4);
    busy_cnt = 0;
    run_all();
    chk("t1_busy_len", 32'(busy_cnt), 56);

    // 7O2 0xC1
    cfg(2, 0, 1, 1, 1);
    wq.push_back(8'hC1);
    add_idle(2);
    add_frame(8'hC1, 0, 1, 1, 1, 2);
    run_all();

    // fill FIFO while a frame is on the line; 0x10 dropped
    cfg(2, 1, 0, 0, 0);
    wq.push_back(8'hA5);
    for (int i = 0; i <= 16; i++) wq.push_back(8'(i));
    add_idle(2);
    add_frame(8'hA5, 1, 0, 0, 0, 2);
    for (int i = 0; i < 16; i++) begin
      add_idle(1);
      add_frame(8'(i), 1, 0, 0, 0, 2);
    end
    repeat (18) step();
    chk("t3_count_full", 32'(bus.count), 16);
    chk("t3_txrdy", 32'(bus.TxRdy), 0);
    chk("t3_ovf_set", 32'(bus.ovf), 1);
    bus.clr_ovf = 1'b1;
    wq.push_back(8'h77);
    step();
    bus.clr_ovf = 1'b0;
    chk("t3_ovf_set_wins", 32'(bus.ovf), 1);
    bus.clr_ovf = 1'b1;
    step();
    bus.clr_ovf = 1'b0;
    chk("t3_ovf_clr", 32'(bus.ovf), 0);
    run_all();
    chk("t3_empty", 32'(bus.empty), 1);
    chk("t3_idle", 32'(bus.busy), 0);

    // reset during bit 4 with 3 frames queued
    cfg(4, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) wq.push_back(8'h30 + 8'(i));
    add_idle(2);
    add_frame(8'h30, 1, 0, 0, 0, 4);
    repeat (24) step();
    rst = 1'b1;
    #1;
    chk("t4_tx", 32'(bus.Tx), 1);
    chk("t4_count", 32'(bus.count), 0);
    chk("t4_empty", 32'(bus.empty), 1);
    chk("t4_busy", 32'(bus.busy), 0);
    exp_tx.delete();
    wq.delete();
    step();
    rst = 1'b0;
    busy_cnt = 0;
    repeat (60) step();
    chk("t4_no_frames", 32'(busy_cnt), 0);

    // eight 1->0 mid-frame only affects the next frame
    cfg(2, 1, 0, 0, 0);
    wq.push_back(8'hFF);
    wq.push_back(8'h3C);
    add_idle(2);
    add_frame(8'hFF, 1, 0, 0, 0, 2);
    add_idle(1);
    add_frame(8'h3C, 0, 0, 0, 0, 2);
    repeat (10) step();
    bus.eight = 1'b0;
    run_all();

    // randomized bursts with random frame config
    for (int it = 0; it < 8; it++) begin
      kk  = int'($urandom_range(1, 3));
      e8  = 1'($urandom);
      p   = 1'($urandom);
      odd = 1'($urandom);
      two = 1'($urandom);
      n   = int'($urandom_range(1, 4));
      cfg(kk, e8, p, odd, two);
      add_idle(2);
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom);
        wq.push_back(b);
        if (j != 0) add_idle(1);
        add_frame(b, e8, p, odd, two, kk);
      end
      run_all();
      chk("rnd_empty", 32'(bus.empty), 1);
      chk("rnd_idle", 32'(bus.busy), 0);
    end

`ifdef UART_TX_BREAK_EN
    cfg(4, 1, 0, 0, 0);
    brk = 1'b1;
    wq.push_back(8'h5A);
    repeat (100) exp_tx.push_back(1'b0);
    add_idle(7);
    add_frame(8'h5A, 1, 0, 0, 0, 4);
    repeat (100) step();
    brk = 1'b0;
    run_all();
    chk("brk_empty", 32'(bus.empty), 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
